div_unit: RTL

- Iterative radix-2 divider for the M extension. Executes DIV, DIVU, REM and REMU (funct3[2] = 1) for the EX stage.
- It is the inverse of the single-cycle MUL path: the EX stage stalls while it is busy.
- Results follow RISC-V divide-by-zero and overflow semantics, with no exceptions raised.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_unit_if : request/response bundle between the EX stage and div_unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  ready, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output ready, done, result
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_unit : iterative radix-2 restoring divider (DIV/DIVU/REM/REMU)
// Rev 1.0
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0]  C_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN-1);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [XLEN-1:0]  rem_q,     rem_d;
  logic [XLEN-1:0]  quot_q,    quot_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic             signed_q,  signed_d;
  logic             remop_q,   remop_d;
  logic             qneg_q,    qneg_d;
  logic             rneg_q,    rneg_d;
  logic [XLEN-1:0]  result_q,  result_d;

  logic            w_accept;
  logic            w_signed;
  logic            w_remop;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_rem_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_accept = bus.start & (state_q == S_IDLE) & bus.funct3[2] & ~bus.flush;
  assign w_signed = ~bus.funct3[0];
  assign w_remop  = bus.funct3[1];

  assign w_abs1 = (w_signed & bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
  assign w_abs2 = (w_signed & bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;

  assign w_div0 = (bus.rs2 == '0);
  assign w_ovf  = w_signed & (bus.rs1 == C_MIN) & (bus.rs2 == '1);
  assign w_special_res = w_div0 ? (w_remop ? bus.rs1 : '1)
                                : (w_remop ? '0 : C_MIN);

  // Partial remainder stays below the divisor, so the top bit of the
  // XLEN+1-bit difference is exactly the borrow of the trial subtraction.
  assign w_rem_sh  = {rem_q, quot_q[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, divisor_q};
  assign w_ge      = ~w_rem_sub[XLEN];

  assign w_q_fix = (signed_q & qneg_q) ? -quot_q : quot_q;
  assign w_r_fix = (signed_q & rneg_q) ? -rem_q  : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    remop_d   = remop_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          signed_d = w_signed;
          remop_d  = w_remop;
          qneg_d   = w_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
          rneg_d   = w_signed & bus.rs1[XLEN-1];
          if (w_div0 | w_ovf) begin
            result_d = w_special_res;
            state_d  = S_DONE;
          end else begin
            rem_d     = '0;
            quot_d    = w_abs1;
            divisor_d = w_abs2;
            cnt_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d  = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], w_ge};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = remop_q ? w_r_fix : w_q_fix;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An aborted operation must leave the previously delivered result intact.
    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      remop_q   <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      remop_q   <= remop_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule
`default_nettype wire
